// File: rtl/sb_queue_endpoint.sv
// +----------------------------------------------------------------------------+
// | sb_queue_endpoint: RTL switchboard queue pair (host->device RX queue and   |
// | device->host TX queue) carrying {data, dest, last} words.  Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module sb_queue_endpoint #(
  parameter int DW    = 256,
  parameter int DESTW = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             rx_en,
  input  logic             tx_en,
  input  logic             host_rx_push,
  input  logic [DW-1:0]    host_rx_data,
  input  logic [DESTW-1:0] host_rx_dest,
  input  logic             host_rx_last,
  output logic             host_rx_full,
  output logic [DW-1:0]    rx_data,
  output logic [DESTW-1:0] rx_dest,
  output logic             rx_last,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [DW-1:0]    tx_data,
  input  logic [DESTW-1:0] tx_dest,
  input  logic             tx_last,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             host_tx_pop,
  output logic [DW-1:0]    host_tx_data,
  output logic [DESTW-1:0] host_tx_dest,
  output logic             host_tx_last,
  output logic             host_tx_empty,
  output logic [31:0]      rx_count,
  output logic [31:0]      tx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = DW + DESTW + 1;
  localparam logic [AW:0] c_ptr_one = 1;

  // Low for the first cycle after reset release so tx_ready never rises while in reset.
  logic r_live;

  logic [PW-1:0] r_rx_mem [DEPTH];
  logic [AW:0]   r_rx_wptr;
  logic [AW:0]   r_rx_rptr;
  logic [31:0]   r_rx_count;
  logic          w_rx_empty;
  logic          w_rx_full;
  logic          w_rx_push;
  logic          w_rx_pop;

  logic [PW-1:0] r_tx_mem [DEPTH];
  logic [AW:0]   r_tx_wptr;
  logic [AW:0]   r_tx_rptr;
  logic [31:0]   r_tx_count;
  logic          w_tx_empty;
  logic          w_tx_full;
  logic          w_tx_push;
  logic          w_tx_pop;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_live <= 1'b0;
    else         r_live <= 1'b1;
  end

  // RX queue: host pushes, device pops
  assign w_rx_empty   = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full    = (r_rx_wptr[AW] != r_rx_rptr[AW]) &&
                        (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);
  assign w_rx_push    = host_rx_push & rx_en & ~w_rx_full;
  assign rx_valid     = rx_en & ~w_rx_empty;
  assign w_rx_pop     = rx_valid & rx_ready;
  assign host_rx_full = w_rx_full;
  assign {rx_data, rx_dest, rx_last} = r_rx_mem[r_rx_rptr[AW-1:0]];
  assign rx_count     = r_rx_count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_ptr_one;
      if (w_rx_pop) begin
        r_rx_rptr  <= r_rx_rptr + c_ptr_one;
        r_rx_count <= r_rx_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= {host_rx_data, host_rx_dest, host_rx_last};
  end

  // TX queue: device pushes, host pops
  assign w_tx_empty    = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full     = (r_tx_wptr[AW] != r_tx_rptr[AW]) &&
                         (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
  assign tx_ready      = tx_en & r_live & ~w_tx_full;
  assign w_tx_push     = tx_valid & tx_ready;
  assign w_tx_pop      = host_tx_pop & ~w_tx_empty;
  assign host_tx_empty = w_tx_empty;
  assign {host_tx_data, host_tx_dest, host_tx_last} = r_tx_mem[r_tx_rptr[AW-1:0]];
  assign tx_count      = r_tx_count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_wptr  <= r_tx_wptr + c_ptr_one;
        r_tx_count <= r_tx_count + 32'd1;
      end
      if (w_tx_pop) r_tx_rptr <= r_tx_rptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= {tx_data, tx_dest, tx_last};
  end

endmodule

`default_nettype wire

// File: tb/tb_sb_queue_endpoint.sv
// +----------------------------------------------------------------------------+
// | tb_sb_queue_endpoint: directed scoreboard bench for sb_queue_endpoint,     |
// | with an optional +1-per-byte loopback between RX and TX.  Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sb_queue_endpoint;

  localparam int DW    = 256;
  localparam int DESTW = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [DESTW-1:0] dest;
    logic             last;
  } pkt_t;

  logic             clk = 1'b0;
  logic             nreset;
  logic             rx_en, tx_en;
  logic             host_rx_push;
  pkt_t             host_pkt;
  logic             host_rx_full;
  logic [DW-1:0]    rx_data;
  logic [DESTW-1:0] rx_dest;
  logic             rx_last, rx_valid, rx_ready;
  logic [DW-1:0]    tx_data;
  logic [DESTW-1:0] tx_dest;
  logic             tx_last, tx_valid, tx_ready;
  logic             host_tx_pop;
  logic [DW-1:0]    host_tx_data;
  logic [DESTW-1:0] host_tx_dest;
  logic             host_tx_last, host_tx_empty;
  logic [31:0]      rx_count, tx_count;

  // Device-side model: either a +1-per-byte loopback or directly driven words
  logic             lb;
  logic             man_rx_ready;
  pkt_t             man_tx;
  logic             man_tx_valid;
  logic [DW-1:0]    lb_data;

  always_comb begin
    lb_data = '0;
    for (int i = 0; i < DW / 8; i++) lb_data[i*8 +: 8] = rx_data[i*8 +: 8] + 8'd1;
  end

  assign rx_ready = lb ? tx_ready : man_rx_ready;
  assign tx_valid = lb ? rx_valid : man_tx_valid;
  assign tx_data  = lb ? lb_data  : man_tx.data;
  assign tx_dest  = lb ? rx_dest  : man_tx.dest;
  assign tx_last  = lb ? rx_last  : man_tx.last;

  sb_queue_endpoint #(.DW(DW), .DESTW(DESTW), .DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset), .rx_en(rx_en), .tx_en(tx_en),
    .host_rx_push(host_rx_push), .host_rx_data(host_pkt.data),
    .host_rx_dest(host_pkt.dest), .host_rx_last(host_pkt.last),
    .host_rx_full(host_rx_full),
    .rx_data(rx_data), .rx_dest(rx_dest), .rx_last(rx_last),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_dest(tx_dest), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .host_tx_pop(host_tx_pop), .host_tx_data(host_tx_data),
    .host_tx_dest(host_tx_dest), .host_tx_last(host_tx_last),
    .host_tx_empty(host_tx_empty),
    .rx_count(rx_count), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  int   total  = 0;
  int   passed = 0;
  pkt_t sb_rx[$];
  pkt_t sb_tx[$];
  int   exp_rx = 0;
  int   exp_tx = 0;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic pkt_t mk_pkt(input logic [7:0] base, input int dst, input logic lst);
    pkt_t p;
    for (int i = 0; i < DW / 8; i++) p.data[i*8 +: 8] = base + 8'(i);
    p.dest = DESTW'(dst);
    p.last = lst;
    return p;
  endfunction

  function automatic pkt_t inc_pkt(input pkt_t p);
    pkt_t q = p;
    for (int i = 0; i < DW / 8; i++) q.data[i*8 +: 8] = p.data[i*8 +: 8] + 8'd1;
    return q;
  endfunction

  task automatic push(input pkt_t p);
    host_pkt     = p;
    host_rx_push = 1'b1;
    step();
    host_rx_push = 1'b0;
  endtask

  task automatic tx_head_cmp(input string tag);
    pkt_t e = 'x;
    if (sb_tx.size() > 0) e = sb_tx.pop_front();
    check(tag, {host_tx_data, host_tx_dest, host_tx_last}, e);
  endtask

  task automatic rx_head_cmp(input string tag);
    pkt_t e = 'x;
    if (sb_rx.size() > 0) e = sb_rx.pop_front();
    check(tag, {rx_data, rx_dest, rx_last}, e);
  endtask

  task automatic pop_check(input string tag);
    tx_head_cmp(tag);
    host_tx_pop = 1'b1;
    step();
    host_tx_pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    pkt_t p;
    nreset = 1'b0; rx_en = 1'b1; tx_en = 1'b1; lb = 1'b0;
    man_rx_ready = 1'b0; man_tx_valid = 1'b0; man_tx = '0;
    host_tx_pop = 1'b0; host_rx_push = 1'b1; host_pkt = mk_pkt(8'h11, 5, 1'b1);

    // Reset held with pushes active
    repeat (3) step();
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_tx_empty", host_tx_empty, 1);
    check("rst_rx_full", host_rx_full, 0);
    check("rst_counts", {rx_count, tx_count}, 0);
    host_rx_push = 1'b0;
    nreset = 1'b1;
    step(); step();
    check("post_rst_rx_valid", rx_valid, 0);
    check("post_rst_tx_empty", host_tx_empty, 1);
    check("post_rst_tx_ready", tx_ready, 1);

    // Loopback of a single word, bytes 0x00..0x1F
    lb = 1'b1;
    p = mk_pkt(8'h00, 32'h0000abcd, 1'b1);
    sb_tx.push_back(inc_pkt(p));
    push(p);
    for (int i = 0; i < 10 && host_tx_empty; i++) step();
    check("lb_arrive", host_tx_empty, 0);
    pop_check("lb_pop");
    exp_rx++; exp_tx++;
    check("lb_empty", host_tx_empty, 1);
    check("lb_tx_count", tx_count, exp_tx);
    check("lb_rx_count", rx_count, exp_rx);

    // Fill RX with device stalled; fifth push must be dropped
    lb = 1'b0;
    for (int k = 0; k < 5; k++) begin
      p = mk_pkt(8'h40 + 8'(k), 100 + k, k[0]);
      if (k < 4) sb_rx.push_back(p);
      push(p);
      if (k == 3) check("full_after4", host_rx_full, 1);
    end
    check("full_after5", host_rx_full, 1);
    man_rx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", rx_valid, 1);
      rx_head_cmp("drain_pkt");
      step();
      exp_rx++;
    end
    man_rx_ready = 1'b0;
    check("drain_done", rx_valid, 0);
    check("drain_notfull", host_rx_full, 0);
    check("drain_rx_count", rx_count, exp_rx);

    // TX backpressure: host idle while device streams six words
    man_tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      man_tx = mk_pkt(8'h60 + 8'(k), 200 + k, ~k[0]);
      check("bp_ready", tx_ready, 1);
      sb_tx.push_back(man_tx);
      step();
      exp_tx++;
    end
    man_tx = mk_pkt(8'h64, 204, 1'b0);
    check("bp_full", tx_ready, 0);
    step();
    check("bp_hold", tx_ready, 0);
    pop_check("bp_pop0");
    check("bp_reopen", tx_ready, 1);
    sb_tx.push_back(man_tx);
    step();
    exp_tx++;
    man_tx = mk_pkt(8'h65, 205, 1'b1);
    check("bp_full2", tx_ready, 0);
    pop_check("bp_pop1");
    check("bp_reopen2", tx_ready, 1);
    sb_tx.push_back(man_tx);
    step();
    exp_tx++;
    man_tx_valid = 1'b0;
    for (int k = 0; k < 4; k++) pop_check("bp_drain");
    check("bp_empty", host_tx_empty, 1);
    check("bp_tx_count", tx_count, exp_tx);

    // Enable gating
    tx_en = 1'b0;
    #1;
    check("txen_gate", tx_ready, 0);
    tx_en = 1'b1;
    p = mk_pkt(8'h80, 300, 1'b1);
    sb_rx.push_back(p);
    push(p);
    check("en_valid", rx_valid, 1);
    rx_en = 1'b0;
    #1;
    check("en_gated", rx_valid, 0);
    push(mk_pkt(8'h90, 301, 1'b0));
    man_rx_ready = 1'b1;
    step();
    check("en_still_gated", rx_valid, 0);
    rx_en = 1'b1;
    #1;
    check("en_resume", rx_valid, 1);
    rx_head_cmp("en_pkt");
    step();
    exp_rx++;
    man_rx_ready = 1'b0;
    check("en_dropped", rx_valid, 0);
    check("en_rx_count", rx_count, exp_rx);

    // Loopback streaming with RX held at two entries, bytes wrapping through 0xFF
    lb = 1'b1;
    tx_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      p = mk_pkt(8'hE0 + 8'(2 * k), 400 + k, k[0]);
      sb_tx.push_back(inc_pkt(p));
      push(p);
    end
    tx_en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check("ss_rx_count", rx_count, exp_rx + j);
      check("ss_occupancy", {rx_valid, host_rx_full}, 2'b10);
      p = mk_pkt(8'hE4 + 8'(2 * j), 402 + j, j[0]);
      sb_tx.push_back(inc_pkt(p));
      host_pkt = p;
      host_rx_push = 1'b1;
      if (!host_tx_empty) begin
        tx_head_cmp("ss_pop");
        host_tx_pop = 1'b1;
      end else host_tx_pop = 1'b0;
      step();
    end
    host_rx_push = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb_tx.size() == 0) break;
      if (!host_tx_empty) begin
        tx_head_cmp("ss_drain");
        host_tx_pop = 1'b1;
      end else host_tx_pop = 1'b0;
      step();
    end
    host_tx_pop = 1'b0;
    exp_rx += 18;
    exp_tx += 18;
    check("ss_sb_empty", sb_tx.size(), 0);
    check("ss_tx_empty", host_tx_empty, 1);
    check("ss_counts", {rx_count, tx_count}, {32'(exp_rx), 32'(exp_tx)});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sb_queue_endpoint.md
Name: sb_queue_endpoint

Overview:
- Synthesizable model of a switchboard queue pair: an RX queue, filled by the host, that drives a packet stream into the device.
- A TX queue that accepts a packet stream from the device and is drained by the host.
- Packets are {data, dest, last} words transferred with valid/ready handshakes.
- Used in place of DPI-backed endpoints where the host side is RTL, e.g. loopback benches that modify packets between RX and TX.

Parameters:
DW, 256, packet data width in bits (multiple of 8)
DESTW, 32, destination field width
DEPTH, 4, entries per queue; power of 2, >= 2

Ports:
clk  input  1  clock
nreset  input  1  asynchronous active-low reset
rx_en  input  1  RX queue enabled (models init); 0 forces rx_valid low and rejects host pushes
tx_en  input  1  TX queue enabled; 0 forces tx_ready low
host_rx_push  input  1  host writes one packet into RX queue
host_rx_data  input  DW  packet data to push
host_rx_dest  input  DESTW  packet dest to push
host_rx_last  input  1  packet last flag to push
host_rx_full  output  1  RX queue full
rx_data  output  DW  head-of-RX-queue data
rx_dest  output  DESTW  head dest
rx_last  output  1  head last flag
rx_valid  output  1  RX head valid
rx_ready  input  1  device accepts RX head
tx_data  input  DW  device packet data
tx_dest  input  DESTW  device packet dest
tx_last  input  1  device last flag
tx_valid  input  1  device packet valid
tx_ready  output  1  TX queue can accept
host_tx_pop  input  1  host removes TX head
host_tx_data  output  DW  TX head data
host_tx_dest  output  DESTW  TX head dest
host_tx_last  output  1  TX head last
host_tx_empty  output  1  TX queue empty
rx_count  output  32  packets delivered to device since reset (wraps)
tx_count  output  32  packets accepted from device since reset (wraps)

Behaviour:
Reset:
- Asynchronous assertion on nreset low clears both queues' pointers and occupancy, and both counters.
- Reset values: rx_valid=0, host_rx_full=0, tx_ready=0, host_tx_empty=1, counts=0.
- Data outputs are don't-care while the corresponding valid is low.
- Deassertion is taken synchronously to clk.

RX queue:
- Circular buffer, DEPTH entries, read/write pointers of log2(DEPTH)+1 bits (wrap bit distinguishes full from empty).
- Push accepted when host_rx_push & rx_en & !host_rx_full; the entry becomes visible on rx_* the following cycle (1-cycle latency).
- Pushes to a full or disabled queue are dropped silently.
- rx_valid = rx_en & !empty. Transfer occurs when rx_valid & rx_ready; the head advances and rx_count increments at that edge.
- rx_data/rx_dest/rx_last are held stable while rx_valid & !rx_ready.
- Simultaneous push and pop: both occur, occupancy unchanged.
- Full is evaluated on current occupancy; a push in the same cycle as a pop from a full queue is dropped.

TX queue:
- Same structure. tx_ready = tx_en & !full, with no combinational dependency on tx_valid.
- Transfer on tx_valid & tx_ready stores {tx_data, tx_dest, tx_last} and increments tx_count.
- host_tx_* present the head combinationally from storage. host_tx_empty reflects occupancy.
- host_tx_pop when empty is ignored.
- Simultaneous device write and host pop both occur.
- A write into an empty queue is visible to the host the next cycle.

General:
- Packets are words; last marks end of a multi-word packet and is carried unmodified. dest is carried unmodified.
- Deasserting rx_en/tx_en mid-stream does not flush contents; it only gates handshakes. Contents resume when re-enabled.
- Ordering is strictly FIFO on each queue. No combinational path from rx_ready to tx_ready or between queues.

Test Plan:
- Reset: hold nreset=0 with pushes active -> rx_valid=0, tx_ready=0, host_tx_empty=1, counts=0; deassert -> still empty.
- Loopback with +1 per byte (tx_data byte i = rx_data byte i + 1, last/valid/ready wired through): push data bytes 0x00..0x1F, last=1 -> host pops bytes 0x01..0x20, last=1, tx_count=1.
- Full RX: rx_ready=0, push 5 packets with DEPTH=4 -> host_rx_full=1 after 4th; 5th dropped; drain yields exactly packets 1..4 in order, rx_count=4.
- Backpressure: tx_en=1, host never pops, device streams 6 words -> tx_ready low after 4 accepted; pop one -> tx_ready high next cycle; order preserved.
- Enable gating: rx_en=0 with queued packet -> rx_valid=0; rx_en=1 -> rx_valid=1 with the same packet.
- Simultaneous push/pop on a half-full queue every cycle for 16 cycles -> occupancy constant, 16 packets delivered in order, byte 0xFF+1 wraps to 0x00 in the loopback.
